// File: rtl/axil_cnn_ctrl_slave_if.sv
// ============================================================================
// Module   : axil_cnn_ctrl_slave_if
// Brief    : AXI4-Lite channel bundle for the CNN control slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axil_cnn_ctrl_slave_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

`default_nettype wire

// File: rtl/axil_cnn_ctrl_slave.sv
// ============================================================================
// Module   : axil_cnn_ctrl_slave
// Brief    : AXI4-Lite control/status register slave for the CNN accelerator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axil_cnn_ctrl_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter logic [31:0] ID_VALUE  = 32'hC0DE_0001
) (
   input  wire logic        clk_i,
   input  wire logic        reset_i,
   axil_cnn_ctrl_slave_if.slave bus,
   input  wire logic        cnn_busy_i,
   input  wire logic        cnn_done_i,
   output logic             cnn_start_o,
   output logic [31:0]      cfg_src_addr_o,
   output logic [31:0]      cfg_dst_addr_o,
   output logic [15:0]      cfg_len_o,
   output logic             irq_o
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} rstate_e;

   wstate_e     w_state_q, w_state_d;
   rstate_e     r_state_q, r_state_d;
   logic        aw_have_q, w_have_q;
   logic [31:0] awaddr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [31:0] rdata_q;
   logic        irq_en_q, done_q, start_q;
   logic [31:0] src_q, dst_q;
   logic [15:0] len_q;

   logic        aw_fire, w_fire, ar_fire, wr_commit, wr_ok, wr_start_req;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;
   logic [13:0] wr_idx, rd_idx;
   logic [1:0]  wr_resp, rd_resp;
   logic [31:0] rd_data;
   logic        unused_sig;

   function automatic logic [31:0] bmerge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

   assign aw_fire   = (w_state_q == W_IDLE) && !aw_have_q && bus.awvalid;
   assign w_fire    = (w_state_q == W_IDLE) && !w_have_q  && bus.wvalid;
   assign wr_commit = (w_state_q == W_IDLE) && (aw_have_q || aw_fire) && (w_have_q || w_fire);
   assign ar_fire   = (r_state_q == R_IDLE) && bus.arvalid;

   // Address and data may arrive together or apart; use the latched copy if present.
   assign wr_addr = aw_have_q ? awaddr_q : bus.awaddr;
   assign wr_data = w_have_q  ? wdata_q  : bus.wdata;
   assign wr_strb = w_have_q  ? wstrb_q  : bus.wstrb;
   assign wr_idx  = wr_addr[15:2];
   assign rd_idx  = bus.araddr[15:2];

   assign wr_start_req = (wr_idx == 14'd0) && wr_strb[0] && wr_data[0];

   always_comb begin
      wr_resp = RESP_OKAY;
      if (wr_addr[31:16] != BASE_ADDR[31:16])
         wr_resp = RESP_DECERR;
      else if (wr_idx >= 14'd5 || (wr_start_req && cnn_busy_i))
         wr_resp = RESP_SLVERR;
   end

   assign wr_ok = wr_commit && (wr_resp == RESP_OKAY);

   always_comb begin
      rd_data = 32'h0;
      rd_resp = RESP_OKAY;
      if (bus.araddr[31:16] != BASE_ADDR[31:16]) begin
         rd_resp = RESP_DECERR;
      end else begin
         case (rd_idx)
            14'd0:   rd_data = {30'h0, irq_en_q, 1'b0};
            14'd1:   rd_data = {30'h0, done_q, cnn_busy_i};
            14'd2:   rd_data = src_q;
            14'd3:   rd_data = dst_q;
            14'd4:   rd_data = {16'h0, len_q};
            14'd5:   rd_data = ID_VALUE;
            default: rd_resp = RESP_SLVERR;
         endcase
      end
   end

   always_comb begin
      w_state_d   = w_state_q;
      r_state_d   = r_state_q;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            bus.awready = !aw_have_q;
            bus.wready  = !w_have_q;
            if (wr_commit) w_state_d = W_RESP;
         end
         W_RESP: begin
            bus.bvalid = 1'b1;
            if (bus.bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
      case (r_state_q)
         R_IDLE: begin
            bus.arready = 1'b1;
            if (bus.arvalid) r_state_d = R_RESP;
         end
         R_RESP: begin
            bus.rvalid = 1'b1;
            if (bus.rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         aw_have_q <= 1'b0;
         w_have_q  <= 1'b0;
         awaddr_q  <= 32'h0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         bresp_q   <= RESP_OKAY;
         rdata_q   <= 32'h0;
         rresp_q   <= RESP_OKAY;
         irq_en_q  <= 1'b0;
         done_q    <= 1'b0;
         start_q   <= 1'b0;
         src_q     <= 32'h0;
         dst_q     <= 32'h0;
         len_q     <= 16'h0;
      end else begin
         start_q <= 1'b0;
         if (wr_commit) begin
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            bresp_q   <= wr_resp;
         end else begin
            if (aw_fire) begin
               aw_have_q <= 1'b1;
               awaddr_q  <= bus.awaddr;
            end
            if (w_fire) begin
               w_have_q <= 1'b1;
               wdata_q  <= bus.wdata;
               wstrb_q  <= bus.wstrb;
            end
         end
         if (wr_ok) begin
            case (wr_idx)
               14'd0: if (wr_strb[0]) begin
                  irq_en_q <= wr_data[1];
                  start_q  <= wr_data[0];
               end
               14'd2:   src_q <= bmerge(src_q, wr_data, wr_strb);
               14'd3:   dst_q <= bmerge(dst_q, wr_data, wr_strb);
               14'd4:   len_q <= bmerge({16'h0, len_q}, wr_data, wr_strb) [15:0];
               default: ;
            endcase
         end
         // A completion pulse takes priority over a simultaneous clear.
         done_q <= cnn_done_i |
                   (done_q & ~(wr_ok && (wr_idx == 14'd1) && wr_strb[0] && wr_data[1]));
         if (ar_fire) begin
            rdata_q <= rd_data;
            rresp_q <= rd_resp;
         end
      end
   end

   assign bus.bresp    = bresp_q;
   assign bus.rdata    = rdata_q;
   assign bus.rresp    = rresp_q;
   assign cnn_start_o    = start_q;
   assign cfg_src_addr_o = src_q;
   assign cfg_dst_addr_o = dst_q;
   assign cfg_len_o      = len_q;
   assign irq_o          = done_q & irq_en_q;

   assign unused_sig = ^{bus.awprot, bus.arprot, wr_addr[1:0], bus.araddr[1:0]};

endmodule

`default_nettype wire
